// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative radix-2 RV32M multiply/divide unit
// Shift-add multiply and restoring divide, one step per cycle, one operation in flight.
module mdu_iter #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [XLEN-1:0] req_a_i,
  input  logic [XLEN-1:0] req_b_i,
  input  logic [TAGW-1:0] req_tag_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_data_o,
  output logic [TAGW-1:0] resp_tag_o
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic              negr_q;
  logic [XLEN-1:0]   dvsr;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quo;
  logic [2*XLEN-1:0] prod;
  logic [CW-1:0]     cnt;

  // Request decode: operand signedness, magnitudes and the divide corner cases
  logic            is_div, a_signed, b_signed, sa, sb, div_zero, div_ovf, accept;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    is_div   = req_op_i[2];
    a_signed = (req_op_i == 3'd1) || (req_op_i == 3'd2) || (req_op_i == 3'd4) || (req_op_i == 3'd6);
    b_signed = (req_op_i == 3'd1) || (req_op_i == 3'd4) || (req_op_i == 3'd6);
    sa       = a_signed & req_a_i[XLEN-1];
    sb       = b_signed & req_b_i[XLEN-1];
    mag_a    = sa ? -req_a_i : req_a_i;
    mag_b    = sb ? -req_b_i : req_b_i;
    div_zero = is_div && (req_b_i == '0);
    div_ovf  = is_div && !req_op_i[0] && (req_a_i == MIN_NEG) && (req_b_i == '1);
    accept   = (state == IDLE) && req_valid_i && !flush_i;
  end

  // One iteration of each algorithm, plus the signed fix-up of the finished magnitudes
  logic [XLEN:0]     mul_sum, shifted;
  logic [2*XLEN-1:0] prod_nxt, prod_fix;
  logic [XLEN-1:0]   rem_nxt, quo_nxt, quo_fix, rem_fix, result;
  logic              ge;

  always_comb begin
    mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, dvsr} : '0);
    prod_nxt = {mul_sum, prod[XLEN-1:1]};
    shifted  = {rem, quo[XLEN-1]};
    ge       = shifted >= {1'b0, dvsr};
    rem_nxt  = ge ? XLEN'(shifted - {1'b0, dvsr}) : shifted[XLEN-1:0];
    quo_nxt  = {quo[XLEN-2:0], ge};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -quo : quo;
    rem_fix  = negr_q ? -rem : rem;
    if (op_q[2])
      result = op_q[1] ? rem_fix : quo_fix;
    else if (op_q[1:0] == 2'd0)
      result = prod_fix[XLEN-1:0];
    else
      result = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid_i) state_nxt = BUSY;
      BUSY:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (resp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_comb begin
    req_ready_o  = (state == IDLE);
    resp_valid_o = (state == DONE);
  end

  // Special divides preload the final quotient/remainder with cnt=0 so BUSY only runs the fix-up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      neg_q       <= 1'b0;
      negr_q      <= 1'b0;
      dvsr        <= '0;
      rem         <= '0;
      quo         <= '0;
      prod        <= '0;
      cnt         <= '0;
      resp_data_o <= '0;
      resp_tag_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q       <= req_op_i;
            resp_tag_o <= req_tag_i;
            prod       <= {{XLEN{1'b0}}, mag_b};
            dvsr       <= is_div ? mag_b : mag_a;
            if (div_zero) begin
              cnt    <= '0;
              neg_q  <= 1'b0;
              negr_q <= 1'b0;
              quo    <= '1;
              rem    <= req_a_i;
            end else if (div_ovf) begin
              cnt    <= '0;
              neg_q  <= 1'b0;
              negr_q <= 1'b0;
              quo    <= req_a_i;
              rem    <= '0;
            end else begin
              cnt    <= CW'(XLEN);
              neg_q  <= sa ^ sb;
              negr_q <= sa;
              quo    <= mag_a;
              rem    <= '0;
            end
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            if (op_q[2]) begin
              rem <= rem_nxt;
              quo <= quo_nxt;
            end else begin
              prod <= prod_nxt;
            end
          end else begin
            resp_data_o <= result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
